// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule controller: FSM states, datapath step codes
// and the default round count.
package aes_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLoad    = 3'd1,
      StStep    = 3'd2,
      StWb      = 3'd3,
      StPresent = 3'd4,
      StDone    = 3'd5
   } state_e;

   localparam logic [2:0] CNT_HOLD  = 3'd0;
   localparam logic [2:0] CNT_FIRST = 3'd1;
   localparam logic [2:0] CNT_LAST  = 3'd6;
   localparam logic [2:0] CNT_WB    = 3'd7;

   localparam int unsigned AES128_ROUNDS = 10;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Control/handshake bundle between the key-schedule controller and its environment.
// master = controller side, slave = environment side.
interface aes_key_sched_ctrl_if;

   logic       start;
   logic       abort;
   logic [3:0] round_o;
   logic [2:0] cnt_o;
   logic       rk_valid;
   logic       rk_ready;
   logic [3:0] rk_round;
   logic       busy;
   logic       done;

   modport master (
      input  start, abort, rk_ready,
      output round_o, cnt_o, rk_valid, rk_round, busy, done
   );

   modport slave (
      output start, abort, rk_ready,
      input  round_o, cnt_o, rk_valid, rk_round, busy, done
   );

endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES key_expansion datapath: walks each round through six compute steps
// and a write-back, then presents the round key on a valid/ready handshake.
module aes_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
   input  logic                  clk,
   input  logic                  rst,
   aes_key_sched_ctrl_if.master  bus
);

   localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      cnt_d   = cnt_q;
      if (bus.abort) begin
         // Cancel wins over start and over a pending handshake.
         state_d = StIdle;
         round_d = '0;
         cnt_d   = CNT_HOLD;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_d = StLoad;
                  round_d = '0;
               end
            end
            StLoad:    state_d = StPresent;
            StPresent: begin
               if (bus.rk_ready) begin
                  if (round_q == LastRound) begin
                     state_d = StDone;
                  end else begin
                     state_d = StStep;
                     round_d = round_q + 4'd1;
                     cnt_d   = CNT_FIRST;
                  end
               end
            end
            StStep: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = StWb;
                  cnt_d   = CNT_HOLD;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            StWb:      state_d = StPresent;
            StDone: begin
               state_d = StIdle;
               round_d = '0;
            end
            default: begin
               state_d = StIdle;
               round_d = '0;
               cnt_d   = CNT_HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         round_q <= '0;
         cnt_q   <= CNT_HOLD;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore decode; round_q is cleared on every return to idle so round_o needs no gating.
   always_comb begin
      bus.round_o  = round_q;
      bus.rk_round = round_q;
      bus.rk_valid = (state_q == StPresent);
      bus.busy     = (state_q != StIdle);
      bus.done     = (state_q == StDone);
      unique case (state_q)
         StStep:  bus.cnt_o = cnt_q;
         StWb:    bus.cnt_o = CNT_WB;
         default: bus.cnt_o = CNT_HOLD;
      endcase
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10; it is the number of expansion rounds, legal range 10..14.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  request to begin an expansion; sampled only in IDLE.
REQ-005 abort  in  1  synchronous cancel of the current expansion.
REQ-006 round_o  out  4  round index driven to the key_expansion datapath.
REQ-007 cnt_o  out  3  step code driven to the datapath: 0=hold, 1..6=compute, 7=write-back.
REQ-008 rk_valid  out  1  a round key is available in the datapath.
REQ-009 rk_ready  in  1  the consumer accepts the presented round key.
REQ-010 rk_round  out  4  index of the presented round key.
REQ-011 busy  out  1  an expansion is in progress.
REQ-012 done  out  1  one-cycle pulse when the expansion completes.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, STEP, WB, PRESENT and DONE; all outputs SHALL be Moore outputs decoded from registered state.
REQ-014 IDLE: round_o=0, cnt_o=0, busy=0; start=1 -> LOAD.
REQ-015 LOAD: exactly one cycle; round_o=0, cnt_o=0 (datapath loads key_in); busy=1; next state PRESENT with rk_round=0.
REQ-016 PRESENT: rk_valid=1, cnt_o=0; hold until rk_ready=1.
REQ-017 On the PRESENT handshake with round_o==NUM_ROUNDS, the next state SHALL be DONE.
REQ-018 On any other PRESENT handshake, round_o SHALL increment and the next state SHALL be STEP with cnt_o=1.
REQ-019 STEP: cnt_o SHALL advance 1,2,...,6, one value per cycle, with no stalls; after cnt_o=6 the next state SHALL be WB.
REQ-020 WB: exactly one cycle with cnt_o=7; next state PRESENT with rk_round=round_o.
REQ-021 rk_valid and rk_round SHALL remain stable from assertion until the handshake; rk_valid SHALL drop the cycle after the handshake.
REQ-022 DONE: done=1 and busy=1 for exactly one cycle; next state IDLE.
REQ-023 The per-round latency SHALL be 8 cycles (6 STEP, 1 WB, 1 PRESENT) when rk_ready is held at 1.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 abort=1 SHALL force IDLE on the next edge from any state, with no done pulse; abort SHALL take priority over start and over rk_ready.
REQ-026 round_o SHALL never exceed NUM_ROUNDS.
REQ-027 cnt_o SHALL be 0 in every state other than STEP and WB.

Reset
REQ-028 While rst=1 the block SHALL be in state IDLE with round_o=0, cnt_o=0, rk_valid=0, rk_round=0, busy=0 and done=0, taking effect asynchronously.
REQ-029 Reset asserted mid-expansion SHALL abandon the expansion without a done pulse; after release the block SHALL wait for a new start.

Structure
REQ-030 The shared package aes_pkg SHALL hold the FSM state enum, the step codes CNT_HOLD=0, CNT_FIRST=1, CNT_LAST=6 and CNT_WB=7, and the default round count AES128_ROUNDS=10.
REQ-031 The block SHALL be a single FSM module with no sub-modules; round_o and cnt_o SHALL connect directly to round and cnt of key_expansion in the parent aes_key_top.

Verification
REQ-032 Nominal run: rk_ready=1, start pulse at cycle 0 -> LOAD at cycle 1; PRESENT rk_round=k at cycle 2+8k; rk_round=10 at cycle 82; done pulse at cycle 83; IDLE at cycle 84; exactly 11 handshakes.
REQ-033 Back-pressure: rk_ready=0 for 5 cycles during PRESENT of round 3 -> rk_valid=1 and rk_round=3 held stable, cnt_o=0; done pulse arrives 5 cycles later than in REQ-032.
REQ-034 Abort: abort=1 during STEP with round_o=4, cnt_o=3 -> next cycle IDLE with busy=0, cnt_o=0, round_o=0 and no done pulse.
REQ-035 Collisions: start during busy -> ignored, sequence unchanged; start and abort together in IDLE -> stays IDLE.
REQ-036 Async reset: rst raised mid-STEP between clock edges -> outputs reach their reset values before the next edge; a new start afterwards reproduces REQ-032.
REQ-037 Parameter: NUM_ROUNDS=14 -> 15 handshakes, last rk_round=14, done pulse at cycle 115.
